// File: rtl/addr_route_ctrl.sv
// Request router between a single master and a shared slave channel.
// Forwards decoded requests in order, locks the target slave while transactions are in flight, and answers decode misses locally.
module addr_route_ctrl #(
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned SelWidth       = 2,
  parameter int unsigned MaxOutstanding = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [AddrWidth-1:0] req_addr,
  output logic [AddrWidth-1:0] dec_addr,
  input  logic [SelWidth-1:0]  dec_sel,
  input  logic                 dec_valid,
  input  logic                 dec_error,
  output logic                 mst_valid,
  input  logic                 mst_ready,
  output logic [SelWidth-1:0]  mst_sel,
  output logic [AddrWidth-1:0] mst_addr,
  input  logic                 slv_rsp_valid,
  output logic                 slv_rsp_ready,
  input  logic                 slv_rsp_err,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_err,
  output logic                 busy,
  output logic                 proto_err
);

  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
  localparam logic [CntW-1:0] MaxCnt = CntW'(MaxOutstanding);

  typedef enum logic {
    RUN     = 1'b0,
    ERR_RSP = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CntW-1:0]     r_cnt;
  logic [SelWidth-1:0] r_cur_sel;
  logic                r_en;
  logic                r_proto_err;

  logic w_cnt_zero;
  logic w_fwd;
  logic w_req_hs;
  logic w_rsp_hs;
  logic w_unexp;

  assign dec_addr = req_addr;
  assign mst_addr = req_addr;
  assign mst_sel  = dec_sel;

  assign w_cnt_zero = (r_cnt == '0);
  // dec_error wins over dec_valid; a different target is held until the pipe drains.
  assign w_fwd = r_en & req_valid & dec_valid & ~dec_error
               & (w_cnt_zero | (dec_sel == r_cur_sel))
               & (r_cnt < MaxCnt);

  assign w_req_hs = mst_valid & mst_ready;
  assign w_rsp_hs = slv_rsp_valid & slv_rsp_ready;

  assign busy      = ~w_cnt_zero | (r_state == ERR_RSP);
  assign proto_err = r_proto_err;

  // NOTE: every output of this block gets a default first, so no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt   = r_state;
    req_ready     = 1'b0;
    mst_valid     = 1'b0;
    slv_rsp_ready = 1'b0;
    rsp_valid     = 1'b0;
    rsp_err       = 1'b0;
    w_unexp       = 1'b0;
    unique case (r_state)
      RUN: begin
        if (r_en) begin
          mst_valid     = w_fwd;
          req_ready     = w_fwd & mst_ready;
          rsp_valid     = slv_rsp_valid & ~w_cnt_zero;
          rsp_err       = slv_rsp_err;
          slv_rsp_ready = rsp_ready & ~w_cnt_zero;
          if (req_valid && dec_error && w_cnt_zero) begin
            req_ready   = 1'b1;
            w_state_nxt = ERR_RSP;
          end
        end
        // Late responses right after reset also land here and are flagged.
        w_unexp = slv_rsp_valid & w_cnt_zero;
      end
      ERR_RSP: begin
        rsp_valid = 1'b1;
        rsp_err   = 1'b1;
        if (rsp_ready) w_state_nxt = RUN;
      end
      default: w_state_nxt = RUN;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= RUN;
      r_cnt       <= '0;
      r_cur_sel   <= '0;
      r_en        <= 1'b0;
      r_proto_err <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_en    <= 1'b1;
      if (w_unexp) r_proto_err <= 1'b1;
      if (w_req_hs) r_cur_sel <= dec_sel;
      if (w_req_hs && !w_rsp_hs) begin
        r_cnt <= r_cnt + 1'b1;
      end else if (w_rsp_hs && !w_req_hs) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_addr_route_ctrl.sv
// Directed bench for addr_route_ctrl: a cycle-by-cycle vector table plus hand-written reset sequences.
// The external decoder is modelled here: 0x0000_xxxx hits, 0xBEEF_xxxx raises both hit and miss, anything else misses.
module tb_addr_route_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] dec_addr;
  logic [1:0]  dec_sel;
  logic        dec_valid;
  logic        dec_error;
  logic        mst_valid;
  logic        mst_ready;
  logic [1:0]  mst_sel;
  logic [31:0] mst_addr;
  logic        slv_rsp_valid;
  logic        slv_rsp_ready;
  logic        slv_rsp_err;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_err;
  logic        busy;
  logic        proto_err;

  int n_checks = 0;
  int n_fail   = 0;

  addr_route_ctrl #(.AddrWidth(32), .SelWidth(2), .MaxOutstanding(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .dec_addr(dec_addr), .dec_sel(dec_sel), .dec_valid(dec_valid), .dec_error(dec_error),
    .mst_valid(mst_valid), .mst_ready(mst_ready), .mst_sel(mst_sel), .mst_addr(mst_addr),
    .slv_rsp_valid(slv_rsp_valid), .slv_rsp_ready(slv_rsp_ready), .slv_rsp_err(slv_rsp_err),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_err(rsp_err),
    .busy(busy), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  always_comb begin
    dec_valid = (dec_addr[31:16] == 16'h0000) || (dec_addr[31:16] == 16'hBEEF);
    dec_error = (dec_addr[31:16] != 16'h0000);
    dec_sel   = dec_addr[13:12];
  end

  // exp packs {req_ready, mst_valid, slv_rsp_ready, rsp_valid, rsp_err, busy, proto_err}.
  typedef struct {
    logic        rv;
    logic [31:0] addr;
    logic        mr;
    logic        sv;
    logic        se;
    logic        rr;
    logic [6:0]  exp;
  } vec_t;

  vec_t vecs[$];

  localparam logic [31:0] A0 = 32'h0000_0000;
  localparam logic [31:0] A1 = 32'h0000_1000;
  localparam logic [31:0] A2 = 32'h0000_2000;
  localparam logic [31:0] A3 = 32'h0000_3000;
  localparam logic [31:0] AE = 32'hDEAD_0000;
  localparam logic [31:0] AB = 32'hBEEF_2000;

  function automatic vec_t mk(input logic rv, input logic [31:0] addr, input logic mr,
                              input logic sv, input logic se, input logic rr, input logic [6:0] exp);
    vec_t v;
    v.rv = rv; v.addr = addr; v.mr = mr; v.sv = sv; v.se = se; v.rr = rr; v.exp = exp;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] outs();
    return {req_ready, mst_valid, slv_rsp_ready, rsp_valid, rsp_err, busy, proto_err};
  endfunction

  task automatic drive(input logic rv, input logic [31:0] addr, input logic mr,
                       input logic sv, input logic se, input logic rr);
    req_valid = rv; req_addr = addr; mst_ready = mr;
    slv_rsp_valid = sv; slv_rsp_err = se; rsp_ready = rr;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b1, A1, 1'b1, 1'b1, 1'b0, 1'b1);

    // First row sits in the cycle right after reset release, before enable.
    vecs.push_back(mk(1, A1, 1, 0, 0, 0, 7'b0000000));
    vecs.push_back(mk(1, A1, 1, 0, 0, 0, 7'b1100000));
    vecs.push_back(mk(0, A1, 0, 1, 0, 1, 7'b0011010));
    vecs.push_back(mk(0, A0, 0, 0, 0, 0, 7'b0000000));
    // Two to slave 0 (one stalled by mst_ready), then slave 3 held until drained.
    vecs.push_back(mk(1, A0, 1, 0, 0, 0, 7'b1100000));
    vecs.push_back(mk(1, A0, 0, 0, 0, 0, 7'b0100010));
    vecs.push_back(mk(1, A0, 1, 0, 0, 0, 7'b1100010));
    vecs.push_back(mk(1, A3, 1, 0, 0, 0, 7'b0000010));
    vecs.push_back(mk(1, A3, 1, 1, 1, 1, 7'b0011110));
    vecs.push_back(mk(1, A3, 1, 1, 0, 0, 7'b0001010));
    vecs.push_back(mk(1, A3, 1, 1, 0, 1, 7'b0011010));
    vecs.push_back(mk(1, A3, 1, 0, 0, 0, 7'b1100000));
    // Request and response handshakes in the same cycle keep the count at 1.
    vecs.push_back(mk(1, A3, 1, 1, 0, 1, 7'b1111010));
    vecs.push_back(mk(1, A3, 0, 1, 0, 1, 7'b0111010));
    vecs.push_back(mk(0, A0, 0, 0, 0, 0, 7'b0000000));
    // Decode miss with nothing in flight; error response held for 3 cycles.
    vecs.push_back(mk(1, AE, 1, 0, 0, 0, 7'b1000000));
    for (int i = 0; i < 3; i++) vecs.push_back(mk(1, A1, 1, 0, 0, 0, 7'b0001110));
    vecs.push_back(mk(1, A1, 1, 0, 0, 1, 7'b0001110));
    vecs.push_back(mk(1, A1, 1, 0, 0, 0, 7'b1100000));
    // Decode miss (hit and miss both high) waits behind one outstanding response.
    vecs.push_back(mk(1, AB, 1, 0, 0, 0, 7'b0000010));
    vecs.push_back(mk(1, AB, 1, 1, 0, 1, 7'b0011010));
    vecs.push_back(mk(1, AB, 1, 0, 0, 0, 7'b1000000));
    vecs.push_back(mk(0, A0, 0, 0, 0, 1, 7'b0001110));
    vecs.push_back(mk(0, A0, 0, 0, 0, 0, 7'b0000000));
    // Unexpected response: refused, then proto_err sticks.
    vecs.push_back(mk(0, A0, 0, 1, 0, 1, 7'b0000000));
    vecs.push_back(mk(0, A0, 0, 0, 0, 0, 7'b0000001));
    // Fill to eight outstanding; the ninth is held until a response frees a slot.
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(1, A2, 1, 0, 0, 0, (i == 0) ? 7'b1100001 : 7'b1100011));
    vecs.push_back(mk(1, A2, 1, 0, 0, 0, 7'b0000011));
    vecs.push_back(mk(1, A2, 1, 1, 0, 1, 7'b0011011));
    vecs.push_back(mk(1, A2, 1, 0, 0, 0, 7'b1100011));
    for (int i = 0; i < 5; i++) vecs.push_back(mk(0, A0, 0, 1, 0, 1, 7'b0011011));

    repeat (2) @(negedge clk);
    #1;
    check("reset outs", 32'(outs()), 32'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      if (i == 0) rst_n = 1'b1;
      drive(vecs[i].rv, vecs[i].addr, vecs[i].mr, vecs[i].sv, vecs[i].se, vecs[i].rr);
      #1;
      check($sformatf("v%0d outs", i), 32'(outs()), 32'(vecs[i].exp));
      check($sformatf("v%0d mst_sel", i), 32'(mst_sel), 32'(vecs[i].addr[13:12]));
      check($sformatf("v%0d dec_addr", i), dec_addr, vecs[i].addr);
      check($sformatf("v%0d mst_addr", i), mst_addr, vecs[i].addr);
    end

    // Three transactions in flight: asynchronous reset clears everything at once.
    @(negedge clk);
    drive(1'b1, A2, 1'b1, 1'b1, 1'b0, 1'b1);
    #1;
    check("pre-reset busy", 32'(busy), 32'h1);
    rst_n = 1'b0;
    #1;
    check("mid-reset outs", 32'(outs()), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, A0, 1'b0, 1'b1, 1'b0, 1'b1);
    #1;
    check("post-reset late rsp", 32'(outs()), 32'h0);
    @(negedge clk);
    #1;
    check("post-reset proto_err", 32'(outs()), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/addr_route_ctrl.md
Name: addr_route_ctrl

Overview:
- Sequences single-master requests through an external combinational address decoder and forwards each decoded request to a shared slave-side channel.
- Enforces in-order responses:
  - tracks the outstanding transaction count;
  - locks the target slave while any transaction is in flight;
  - locally terminates requests that fail decode with an error response.
- Sits between the master port and the slave demux/crossbar.

Parameters:
- AddrWidth, 32, request address width.
- SelWidth, 2, slave index width; must match the decoder's index output.
- MaxOutstanding, 8, maximum in-flight transactions (≥1). Counter width is clog2(MaxOutstanding+1).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  master request valid.
- req_ready  out  1  master request accepted.
- req_addr  in  AddrWidth  master request address.
- dec_addr  out  AddrWidth  address to decoder; always equals req_addr (combinational).
- dec_sel  in  SelWidth  decoder slave index.
- dec_valid  in  1  decoder hit.
- dec_error  in  1  decoder miss.
- mst_valid  out  1  forwarded request valid.
- mst_ready  in  1  slave side accepts request.
- mst_sel  out  SelWidth  target slave index; equals dec_sel.
- mst_addr  out  AddrWidth  forwarded address; equals req_addr.
- slv_rsp_valid  in  1  slave response valid.
- slv_rsp_ready  out  1  slave response accepted.
- slv_rsp_err  in  1  slave response error.
- rsp_valid  out  1  master response valid.
- rsp_ready  in  1  master accepts response.
- rsp_err  out  1  master response error.
- busy  out  1  outstanding count nonzero or state is ERR_RSP.
- proto_err  out  1  sticky; set by an unexpected slave response.

Behaviour:
- Reset values (async, rst_n low):
  - state=RUN, cnt=0, cur_sel=0, proto_err=0, en=0.
  - All valid/ready outputs are 0 while en=0.
  - en sets on the first clk edge after release, so the first handshake is possible in the second cycle after release.
- States: RUN, ERR_RSP.
- Forwarding condition, RUN only:
  - fwd = en & req_valid & dec_valid & !dec_error & (cnt==0 | dec_sel==cur_sel) & cnt<MaxOutstanding.
  - mst_valid=fwd; req_ready=fwd & mst_ready. Zero-latency pass-through.
  - On the mst handshake: cnt+1, cur_sel<=dec_sel.
- Target lock: a request to a different slave while cnt>0 is held (req_ready=0) until cnt reaches 0.
- Decode error, in RUN with en & req_valid & dec_error:
  - If cnt==0: req_ready=1, mst_valid=0, next state ERR_RSP.
  - If cnt>0: req_ready=0 and the request waits for drain.
  - dec_valid and dec_error both high is treated as an error.
- ERR_RSP:
  - rsp_valid=1, rsp_err=1, slv_rsp_ready=0, req_ready=0, mst_valid=0.
  - On rsp_ready: next state RUN.
  - A new request is accepted no earlier than the cycle after the error response handshake.
- Response path, RUN:
  - rsp_valid = slv_rsp_valid & cnt>0; rsp_err=slv_rsp_err; slv_rsp_ready = rsp_ready & cnt>0.
  - On the response handshake: cnt-1.
- Unexpected response: slv_rsp_valid with cnt==0 in RUN.
  - Not accepted (slv_rsp_ready=0); proto_err<=1, held until reset.
- Simultaneous request and response handshakes in the same cycle: cnt unchanged; cur_sel updates to the new request's target.
- cnt never exceeds MaxOutstanding and never underflows.
- Reset mid-transaction: all state is discarded immediately; in-flight responses arriving after reset count as unexpected.
- Valid outputs never depend on ready inputs of the same channel. req_ready depends on mst_ready (pass-through); no combinational loop exists through the decoder.

Test Plan:
- Reset release, then a request to addr 0x1000 decoding to sel=1 with mst_ready=1 → mst_valid in cycle 2 after release, req_ready=1, cnt=1; slave response err=0 → rsp_valid=1, rsp_err=0, cnt=0, busy=0.
- Eight back-to-back requests to sel=2, no responses, MaxOutstanding=8 → 8 accepted; the 9th is held with req_ready=0 until one response returns, then accepted the same cycle the counter drops.
- Two requests to sel=0 outstanding, then a request to sel=3 → held until both responses complete and cnt=0, then forwarded with mst_sel=3.
- Decode miss, dec_error=1 with cnt=0 → req_ready=1 for one cycle, mst_valid=0; next cycle rsp_valid=1, rsp_err=1. Hold rsp_ready=0 for 3 cycles → response held stable; then RUN.
- Decode miss with cnt=1 → not accepted until the outstanding response completes; then the error response is returned after the slave response (order preserved).
- slv_rsp_valid=1 with cnt=0 → slv_rsp_ready=0, proto_err=1 and sticky. Assert rst_n low with cnt=3 → cnt=0, all valid outputs 0 immediately.
